// File: rtl/zsdram_pkg.sv
// Shared definitions for the SDRAM write-port arbiter slice.
// Holds the default bus widths, the burst length and the arbiter FSM state encoding.
// Also holds the round-robin pointer advance helper.
package zsdram_pkg;

  // Bank(2) + Row(13) + Column(9)
  localparam int SDRAM_ADDR_W = 24;
  localparam int SDRAM_DATA_W = 16;
  // Each SDRAM write moves a fixed burst of four data words.
  localparam int BURST_WORDS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_RELEASE = 2'd3
  } wr_state_e;

  // Index of the client after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sdram_wr_arbiter_if.sv
// SDRAM controller write-port bundle: one address, four burst data words, a level request and a done pulse.
// Ports: wr_addr, wr_data1..4 and wr_req are driven by the arbiter (master); wr_done is driven by the
// controller (slave) as a one-cycle pulse.
interface sdram_wr_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data1;
  logic [DATA_W-1:0] wr_data2;
  logic [DATA_W-1:0] wr_data3;
  logic [DATA_W-1:0] wr_data4;
  logic              wr_req;
  logic              wr_done;

  modport master (
    output wr_addr, wr_data1, wr_data2, wr_data3, wr_data4, wr_req,
    input  wr_done
  );

  modport slave (
    input  wr_addr, wr_data1, wr_data2, wr_data3, wr_data4, wr_req,
    output wr_done
  );
endinterface

// File: rtl/zrr_pick.sv
// Combinational round-robin pick: the first asserted request found searching upward from ptr_i, wrapping.
// Ports: req_i (request vector), ptr_i (search start) -> vld_o (any request), onehot_o, idx_o (winner).
// Pure logic with no state; outputs are zero when no request is asserted.
module zrr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic               vld_o,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [PTR_W-1:0]   idx_o
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    vld_o    = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    cand     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = PTR_W'((int'(ptr_i) + off) % NUM_REQ);
      if (!vld_o && req_i[cand]) begin
        vld_o          = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_wr_arbiter.sv
// Round-robin arbiter sharing one SDRAM write port (address + 4-word burst) between NUM_REQ clients.
// Ports: clk, rst (sync, active-high), en (gates new grants), iReq/iAddr/iData per client,
// oDone (one-cycle per-client pulse), oGrant (one-hot owner), oTimeout_Err, sdram (controller bundle).
// Optional macro WR_TIMEOUT_EN: bounds the wait for wr_done to TIMEOUT_CYC cycles and flags a sticky error.
module sdram_wr_arbiter
  import zsdram_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = SDRAM_ADDR_W,
  parameter int DATA_W      = SDRAM_DATA_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic [NUM_REQ-1:0]                  iReq,
  input  logic [NUM_REQ*ADDR_W-1:0]           iAddr,
  input  logic [NUM_REQ*BURST_WORDS*DATA_W-1:0] iData,
  output logic [NUM_REQ-1:0]                  oDone,
  output logic [NUM_REQ-1:0]                  oGrant,
  output logic                                oTimeout_Err,
  sdram_wr_arbiter_if.master                  sdram
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("sdram_wr_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYC at least 2");
  end

  // Packed views of the flat client buses: element k is client k.
  logic [NUM_REQ-1:0][ADDR_W-1:0]                  cli_addr;
  logic [NUM_REQ-1:0][BURST_WORDS-1:0][DATA_W-1:0] cli_data;
  assign cli_addr = iAddr;
  assign cli_data = iData;

  wr_state_e                         state_q, state_d;
  logic [PTR_W-1:0]                  ptr_q, ptr_d;
  logic [PTR_W-1:0]                  idx_q, idx_d;
  logic [NUM_REQ-1:0]                grant_q, grant_d;
  logic [NUM_REQ-1:0]                done_q, done_d;
  logic                              req_q, req_d;
  logic [ADDR_W-1:0]                 addr_q, addr_d;
  logic [BURST_WORDS-1:0][DATA_W-1:0] data_q, data_d;

  logic                              pick_vld;
  logic [NUM_REQ-1:0]                pick_onehot;
  logic [PTR_W-1:0]                  pick_idx;

`ifdef WR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timeout_hit;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic             timeout_hit;
  assign timeout_hit = 1'b0;
`endif

  zrr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i    (iReq),
    .ptr_i    (ptr_q),
    .vld_o    (pick_vld),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    done_d  = '0;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef WR_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (en && pick_vld) begin
          grant_d = pick_onehot;
          idx_d   = pick_idx;
          addr_d  = cli_addr[pick_idx];
          data_d  = cli_data[pick_idx];
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // Address/data have been stable for one cycle; raise the request on the way into ISSUE.
        req_d   = 1'b1;
        state_d = ST_ISSUE;
`ifdef WR_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_ISSUE: begin
        if (sdram.wr_done || timeout_hit) begin
          req_d   = 1'b0;
          done_d  = grant_q;
          ptr_d   = PTR_W'(rr_next(int'(idx_q), NUM_REQ));
          state_d = ST_RELEASE;
`ifdef WR_TIMEOUT_EN
          // A done arriving on the final counted cycle still counts as a clean completion.
          if (!sdram.wr_done) begin
            err_d = 1'b1;
          end
`endif
        end
`ifdef WR_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RELEASE: begin
        // Gap cycle so the served client can drop iReq before requests are sampled again.
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef WR_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef WR_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign oGrant         = grant_q;
  assign oDone          = done_q;
  assign sdram.wr_addr  = addr_q;
  assign sdram.wr_data1 = data_q[0];
  assign sdram.wr_data2 = data_q[1];
  assign sdram.wr_data3 = data_q[2];
  assign sdram.wr_data4 = data_q[3];
  assign sdram.wr_req   = req_q;

`ifdef WR_TIMEOUT_EN
  assign oTimeout_Err = err_q;
`else
  assign oTimeout_Err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_wr_arbiter.sv
module tb_sdram_wr_arbiter;
  localparam int N  = 2;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [N-1:0]                 iReq;
  logic [N-1:0][AW-1:0]         iAddr;
  logic [N-1:0][3:0][DW-1:0]    iData;
  logic [N-1:0]                 oDone;
  logic [N-1:0]                 oGrant;
  logic                         oTimeout_Err;

  sdram_wr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();

  sdram_wr_arbiter #(
    .NUM_REQ     (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .iReq         (iReq),
    .iAddr        (iAddr),
    .iData        (iData),
    .oDone        (oDone),
    .oGrant       (oGrant),
    .oTimeout_Err (oTimeout_Err),
    .sdram        (sif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: per-client bus values and the round-robin start point.
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_data [N][4];
  int            m_ptr;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bus();
    for (int k = 0; k < N; k++) begin
      iAddr[k] = m_addr[k];
      for (int w = 0; w < 4; w++) iData[k][w] = m_data[k][w];
    end
  endtask

  task automatic new_values(input int k);
    m_addr[k] = AW'($urandom);
    for (int w = 0; w < 4; w++) m_data[k][w] = DW'($urandom);
  endtask

  // Winner = first requester met when walking the clients in order starting at ptr.
  function automatic int model_pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Called just after the edge that should have produced the grant for client k.
  task automatic start_and_check(input int k);
    check("grant", oGrant, oh(k));
    check("setup_req_low", sif.wr_req, 1'b0);
    exp_addr = m_addr[k];
    for (int w = 0; w < 4; w++) exp_data[w] = m_data[k][w];
    check("addr", sif.wr_addr, exp_addr);
    check("data1", sif.wr_data1, exp_data[0]);
    check("data2", sif.wr_data2, exp_data[1]);
    check("data3", sif.wr_data3, exp_data[2]);
    check("data4", sif.wr_data4, exp_data[3]);
    // Client changes its bus after the latch; the burst must keep the old values.
    new_values(k);
    drive_bus();
    tick();
    check("issue_req", sif.wr_req, 1'b1);
    check("addr_stable", sif.wr_addr, exp_addr);
    check("data4_stable", sif.wr_data4, exp_data[3]);
  endtask

  // Called while in ISSUE: wait, pulse done, check the completion handshake.
  task automatic finish_burst(input int k, input int delay);
    repeat (delay) tick();
    check("req_hold", sif.wr_req, 1'b1);
    check("no_early_done", oDone, '0);
    sif.wr_done = 1'b1;
    tick();
    sif.wr_done = 1'b0;
    check("done_pulse", oDone, oh(k));
    check("req_drop", sif.wr_req, 1'b0);
    check("grant_held", oGrant, oh(k));
    iReq[k] = 1'b0;
    tick();
    check("done_one_cycle", oDone, '0);
    check("grant_release", oGrant, '0);
    m_ptr = (k + 1) % N;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int start;
    rst = 1'b1;
    en = 1'b1;
    iReq = '0;
    sif.wr_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_addr[i] = '0;
      for (int w = 0; w < 4; w++) m_data[i][w] = '0;
    end
    drive_bus();
    m_ptr = 0;
    repeat (3) tick();

    // Reset state
    check("rst_grant", oGrant, '0);
    check("rst_done", oDone, '0);
    check("rst_req", sif.wr_req, 1'b0);
    check("rst_addr", sif.wr_addr, '0);
    check("rst_data1", sif.wr_data1, '0);
    check("rst_data4", sif.wr_data4, '0);
    check("rst_err", oTimeout_Err, 1'b0);
    rst = 1'b0;
    tick();

    // Single request, fixed values
    m_addr[0] = 24'h012345;
    m_data[0][0] = 16'h1111;
    m_data[0][1] = 16'h2222;
    m_data[0][2] = 16'h3333;
    m_data[0][3] = 16'h4444;
    drive_bus();
    iReq = 2'b01;
    tick();
    start_and_check(0);
    finish_burst(0, 5);

    // Both clients held: strict alternation
    start = m_ptr;
    iReq = 2'b11;
    for (int i = 0; i < 6; i++) begin
      k = (start + i) % N;
      tick();
      start_and_check(k);
      finish_burst(k, int'($urandom_range(0, 3)));
      iReq[k] = 1'b1;
    end

    // Done pulses outside ISSUE are ignored
    iReq = '0;
    sif.wr_done = 1'b1;
    tick();
    sif.wr_done = 1'b0;
    check("idle_done_ignored", oDone, '0);
    check("idle_no_grant", oGrant, '0);
    check("idle_no_req", sif.wr_req, 1'b0);
    iReq = 2'b01;
    tick();
    check("setup_grant", oGrant, 2'b01);
    sif.wr_done = 1'b1;
    tick();
    sif.wr_done = 1'b0;
    check("setup_done_ignored", oDone, '0);
    check("setup_to_issue", sif.wr_req, 1'b1);
    finish_burst(0, 2);

    // en=0 during ISSUE of client 1: burst finishes, then no grants
    iReq = 2'b10;
    tick();
    start_and_check(1);
    en = 1'b0;
    finish_burst(1, 3);
    iReq = 2'b11;
    repeat (8) tick();
    check("en0_no_grant", oGrant, '0);
    check("en0_no_req", sif.wr_req, 1'b0);
    en = 1'b1;
    tick();
    start_and_check(model_pick(iReq, m_ptr));
    finish_burst(0, 1);

    // Reset in ISSUE of client 1 (pointer is 1 here)
    tick();
    start_and_check(1);
    iReq = 2'b11;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_req", sif.wr_req, 1'b0);
    check("rst_mid_grant", oGrant, '0);
    check("rst_mid_done", oDone, '0);
    m_ptr = 0;
    tick();
    start_and_check(model_pick(iReq, m_ptr));
    finish_burst(0, 2);
    tick();
    start_and_check(1);
    finish_burst(1, 0);

    // Missing done from the controller
    iReq = 2'b01;
    tick();
    start_and_check(0);
`ifdef WR_TIMEOUT_EN
    begin
      int highs;
      int guard;
      highs = 1;
      guard = 0;
      while (sif.wr_req === 1'b1 && guard < 200) begin
        tick();
        guard++;
        if (sif.wr_req === 1'b1) highs++;
      end
      check("timeout_len", highs, TO);
      check("timeout_err", oTimeout_Err, 1'b1);
      check("timeout_done", oDone, 2'b01);
      iReq = '0;
      tick();
      check("timeout_done_one", oDone, '0);
      check("timeout_release", oGrant, '0);
      m_ptr = 1;
    end
`else
    begin
      int drops;
      drops = 0;
      repeat (1000) begin
        tick();
        if (sif.wr_req !== 1'b1) drops++;
      end
      check("no_timeout_req_held", drops, 0);
      check("no_timeout_err", oTimeout_Err, 1'b0);
      finish_burst(0, 0);
    end
`endif

    // Randomized traffic against the round-robin model
    for (int it = 0; it < 30; it++) begin
      for (int c = 0; c < N; c++) begin
        if (!iReq[c] && $urandom_range(0, 1) == 1) begin
          new_values(c);
          iReq[c] = 1'b1;
        end
      end
      if (iReq == '0) begin
        k = int'($urandom_range(0, N - 1));
        new_values(k);
        iReq[k] = 1'b1;
      end
      drive_bus();
      if ($urandom_range(0, 3) == 0) begin
        en = 1'b0;
        repeat (3) tick();
        check("rand_en0_no_grant", oGrant, '0);
        en = 1'b1;
      end
      k = model_pick(iReq, m_ptr);
      tick();
      start_and_check(k);
      // Client may give up early; the burst must still complete.
      if ($urandom_range(0, 3) == 0) iReq[k] = 1'b0;
      finish_burst(k, int'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
